irq_req_sequencer: RTL and testbench
====================================

Name: irq_req_sequencer

Overview:
- Requester-side companion to the 27-channel priority interrupt encoder (three 9-channel request buses A/B/C, shared 9-bit enable, bus flags PA/PB/PC, 4-bit channel code).
- Latches interrupt events into pending registers and presents them to the encoder as static request vectors.
- Captures the encoder's winning bus/channel and delivers it to the CPU with a valid/ready handshake.
- Clears the serviced pending bit and re-arbitrates.

Parameters:
- N_CH, 9, channels per bus; width of every request, enable and event vector.
- CHW, 4, width of the channel code.
- SETTLE, 2, cycles of stable request before sampling the encoder result (range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- evt_a  input  N_CH  one-cycle event pulses, bus A; each set bit sets its pending bit.
- evt_b  input  N_CH  event pulses, bus B.
- evt_c  input  N_CH  event pulses, bus C.
- en  input  N_CH  per-channel enable mask, applied to all buses.
- req_a  output  N_CH  registered request vector to encoder bus A (active-high).
- req_b  output  N_CH  request vector, bus B.
- req_c  output  N_CH  request vector, bus C.
- req_e  output  N_CH  registered copy of en driven to the encoder.
- pa  input  1  encoder flag: bus A holds the winner.
- pb  input  1  encoder flag: bus B holds the winner.
- pc  input  1  encoder flag: bus C holds the winner.
- chan  input  CHW  encoder channel code of the winner.
- irq_valid  output  1  serviced interrupt available to the CPU.
- irq_bus  output  2  0=A, 1=B, 2=C; 3 never driven.
- irq_chan  output  CHW  channel index 0..N_CH-1.
- irq_ready  input  1  CPU accepts the interrupt.
- err_code  output  1  one-cycle pulse: encoder returned an illegal code.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending_a/b/c=0; req_a/b/c=0; req_e=0.
  - irq_valid=0; irq_bus=0; irq_chan=0; err_code=0.
  - state=IDLE; settle counter=0.
  - Reset mid-handshake abandons the interrupt; no pending bit survives.
- Pending update, every cycle and in every state: pending_x <= (pending_x & ~clr_x) | evt_x.
  - Set wins over clear on the same bit in the same cycle.
- Request outputs are registered: req_x <= pending_x & en; req_e <= en.
  - Updated every cycle in IDLE.
  - Frozen from leaving IDLE until the next return to IDLE, so the encoder inputs stay stable while it is sampled.
- States:
  - IDLE: when any (pending_x & en) != 0, go to SETTLE. The counter loads SETTLE-1 and the request registers load the current value that cycle.
  - SETTLE: decrement the counter. At 0, sample pa/pb/pc/chan and go to CHECK.
  - CHECK: priority is A > B > C on the flags.
    - No flag set: go to IDLE with no error (the request was withdrawn by en).
    - A flag set and chan >= N_CH: pulse err_code for 1 cycle, go to IDLE, pending unchanged.
    - Otherwise: latch irq_bus/irq_chan, assert irq_valid, go to ACK.
    - Total latency from IDLE exit to irq_valid = SETTLE+1 cycles.
  - ACK: hold irq_valid, irq_bus and irq_chan stable until irq_valid & irq_ready.
    - In that cycle: assert clr on the selected bit, deassert irq_valid next cycle, go to IDLE.
- Only one interrupt is outstanding at a time; a new arbitration never starts while in ACK.
- If the bit's en drops during ACK, the handshake still completes and the bit is still cleared.
- Events arriving during SETTLE/CHECK/ACK are recorded but not presented until the next IDLE.
- Maximum back-to-back rate: one interrupt per SETTLE+3 cycles when irq_ready is tied high.

Test Plan:
- Reset, then evt_a=9'h010, en=9'h1FF, model encoder returns pa=1, chan=4 -> req_a=9'h010 by the cycle after IDLE exit; irq_valid=1 after SETTLE+1 cycles with irq_bus=0, irq_chan=4; irq_ready=1 -> pending_a=0, irq_valid=0 next cycle.
- evt_b=9'h001 and evt_c=9'h100 in the same cycle -> first interrupt irq_bus=1, irq_chan=0, then irq_bus=2, irq_chan=8; both pending bits end 0.
- Pending A bit 3 set, en=9'h000 -> req_a=0, state stays IDLE, no irq_valid. Raising en bit 3 -> interrupt delivered with irq_chan=3.
- evt_a bit 2 reasserted in the same cycle its ACK handshake completes -> pending_a bit 2 stays 1 and a second interrupt for A/2 follows.
- Encoder model returns pa=1, chan=12 -> err_code high for exactly 1 cycle, irq_valid stays 0, pending unchanged, re-arbitration occurs.
- rst_n=0 during ACK with irq_valid=1 -> next cycle irq_valid=0, all req_* and pending cleared, state IDLE.

Source files
------------

// File: rtl/irq_req_sequencer.sv
`default_nettype none
// ============================================================================
// irq_req_sequencer : latches interrupt events, drives the encoder, hands the winner to the CPU
// Revision 1.0
// ============================================================================
module irq_req_sequencer #(
  parameter int N_CH   = 9,
  parameter int CHW    = 4,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] evt_a,
  input  logic [N_CH-1:0] evt_b,
  input  logic [N_CH-1:0] evt_c,
  input  logic [N_CH-1:0] en,
  output logic [N_CH-1:0] req_a,
  output logic [N_CH-1:0] req_b,
  output logic [N_CH-1:0] req_c,
  output logic [N_CH-1:0] req_e,
  input  logic            pa,
  input  logic            pb,
  input  logic            pc,
  input  logic [CHW-1:0]  chan,
  output logic            irq_valid,
  output logic [1:0]      irq_bus,
  output logic [CHW-1:0]  irq_chan,
  input  logic            irq_ready,
  output logic            err_code
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [CHW-1:0]  CH_LIMIT    = CHW'(N_CH);
  localparam logic [N_CH-1:0] ONE_HOT0    = {{(N_CH-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [3:0]      settle_cnt;
  logic [N_CH-1:0] pending_a;
  logic [N_CH-1:0] pending_b;
  logic [N_CH-1:0] pending_c;
  logic            smp_pa;
  logic            smp_pb;
  logic            smp_pc;
  logic [CHW-1:0]  smp_chan;

  logic            any_req;
  logic            handshake;
  logic [N_CH-1:0] sel_bit;
  logic [N_CH-1:0] clr_a;
  logic [N_CH-1:0] clr_b;
  logic [N_CH-1:0] clr_c;

  assign any_req   = |((pending_a | pending_b | pending_c) & en);
  assign handshake = (state == S_ACK) && irq_valid && irq_ready;
  assign sel_bit   = ONE_HOT0 << irq_chan;

  // The serviced bit is cleared regardless of its enable at that moment.
  always_comb begin
    clr_a = '0;
    clr_b = '0;
    clr_c = '0;
    if (handshake) begin
      case (irq_bus)
        2'd0:    clr_a = sel_bit;
        2'd1:    clr_b = sel_bit;
        2'd2:    clr_c = sel_bit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_a  <= '0;
      pending_b  <= '0;
      pending_c  <= '0;
      req_a      <= '0;
      req_b      <= '0;
      req_c      <= '0;
      req_e      <= '0;
      irq_valid  <= 1'b0;
      irq_bus    <= 2'd0;
      irq_chan   <= '0;
      err_code   <= 1'b0;
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      smp_pa     <= 1'b0;
      smp_pb     <= 1'b0;
      smp_pc     <= 1'b0;
      smp_chan   <= '0;
    end else begin
      // A new event on the bit being cleared wins over the clear.
      pending_a <= (pending_a & ~clr_a) | evt_a;
      pending_b <= (pending_b & ~clr_b) | evt_b;
      pending_c <= (pending_c & ~clr_c) | evt_c;
      err_code  <= 1'b0;

      case (state)
        S_IDLE: begin
          req_a <= pending_a & en;
          req_b <= pending_b & en;
          req_c <= pending_c & en;
          req_e <= en;
          if (any_req) begin
            settle_cnt <= SETTLE_INIT;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            smp_pa   <= pa;
            smp_pb   <= pb;
            smp_pc   <= pc;
            smp_chan <= chan;
            state    <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        S_CHECK: begin
          if (smp_pa || smp_pb || smp_pc) begin
            if (smp_chan >= CH_LIMIT) begin
              err_code <= 1'b1;
              state    <= S_IDLE;
            end else begin
              irq_valid <= 1'b1;
              irq_chan  <= smp_chan;
              irq_bus   <= smp_pa ? 2'd0 : (smp_pb ? 2'd1 : 2'd2);
              state     <= S_ACK;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_ACK: begin
          if (handshake) begin
            irq_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_req_sequencer.sv
`default_nettype none
// ============================================================================
// tb_irq_req_sequencer : directed bench with a behavioural priority encoder
// Revision 1.0
// ============================================================================
module tb_irq_req_sequencer;

  logic       clk;
  logic       rst_n;
  logic [8:0] evt_a, evt_b, evt_c, en;
  logic [8:0] req_a, req_b, req_c, req_e;
  logic       pa, pb, pc;
  logic [3:0] chan;
  logic       irq_valid;
  logic [1:0] irq_bus;
  logic [3:0] irq_chan;
  logic       irq_ready;
  logic       err_code;

  logic       force_bad;
  int         checks;
  int         errors;

  irq_req_sequencer #(.N_CH(9), .CHW(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .evt_a(evt_a), .evt_b(evt_b), .evt_c(evt_c), .en(en),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_e(req_e),
    .pa(pa), .pb(pb), .pc(pc), .chan(chan),
    .irq_valid(irq_valid), .irq_bus(irq_bus), .irq_chan(irq_chan),
    .irq_ready(irq_ready), .err_code(err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] lowest(input logic [8:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 8; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Encoder model: bus A > B > C, lowest channel index wins within a bus.
  always_comb begin
    pa = 1'b0; pb = 1'b0; pc = 1'b0; chan = 4'd0;
    if (|(req_a & req_e)) begin
      pa = 1'b1; chan = lowest(req_a & req_e);
    end else if (|(req_b & req_e)) begin
      pb = 1'b1; chan = lowest(req_b & req_e);
    end else if (|(req_c & req_e)) begin
      pc = 1'b1; chan = lowest(req_c & req_e);
    end
    if (force_bad) chan = 4'd12;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!irq_valid && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (!irq_valid) begin
      errors++;
      $display("FAIL wait_valid: irq_valid=%b after %0d cycles, required 1", irq_valid, n);
    end
  endtask

  task automatic ack();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({irq_valid, err_code, irq_bus, irq_chan} !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %h required 00", {irq_valid, err_code, irq_bus, irq_chan});
    end
    checks++;
    if ({req_a, req_b, req_c, req_e} !== 36'h0) begin
      errors++;
      $display("FAIL reset_req: got %h required 0", {req_a, req_b, req_c, req_e});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    en = 9'h1FF;
    evt_a = 9'h010;
    tick();
    evt_a = 9'h000;
    checks++;
    if (dut.pending_a !== 9'h010) begin
      errors++; $display("FAIL basic_pend: got %h required 010", dut.pending_a);
    end
    tick();
    checks++;
    if (req_a !== 9'h010 || irq_valid !== 1'b0) begin
      errors++; $display("FAIL basic_req: req_a=%h valid=%b required 010/0", req_a, irq_valid);
    end
    tick(); tick();
    checks++;
    if (irq_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: valid=%b required 0", irq_valid);
    end
    tick();
    checks++;
    if ({irq_valid, irq_bus, irq_chan} !== {1'b1, 2'd0, 4'd4}) begin
      errors++;
      $display("FAIL basic_irq: valid=%b bus=%0d chan=%0d required 1/0/4", irq_valid, irq_bus, irq_chan);
    end
    ack();
    checks++;
    if (irq_valid !== 1'b0 || dut.pending_a !== 9'h000) begin
      errors++;
      $display("FAIL basic_clear: valid=%b pend=%h required 0/000", irq_valid, dut.pending_a);
    end
    tick(); tick();
  endtask

  task automatic test_two_buses();
    int n;
    evt_b = 9'h001;
    evt_c = 9'h100;
    tick();
    evt_b = 9'h000;
    evt_c = 9'h000;
    wait_valid(10, n);
    checks++;
    if ({irq_bus, irq_chan} !== {2'd1, 4'd0}) begin
      errors++; $display("FAIL two_first: bus=%0d chan=%0d required 1/0", irq_bus, irq_chan);
    end
    ack();
    wait_valid(10, n);
    checks++;
    if ({irq_bus, irq_chan} !== {2'd2, 4'd8}) begin
      errors++; $display("FAIL two_second: bus=%0d chan=%0d required 2/8", irq_bus, irq_chan);
    end
    ack();
    checks++;
    if ({dut.pending_b, dut.pending_c} !== 18'h0) begin
      errors++;
      $display("FAIL two_pend: b=%h c=%h required 000/000", dut.pending_b, dut.pending_c);
    end
    tick(); tick();
  endtask

  task automatic test_enable_mask();
    int n;
    logic seen;
    en = 9'h000;
    evt_a = 9'h008;
    tick();
    evt_a = 9'h000;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (irq_valid) seen = 1'b1;
    end
    checks++;
    if (req_a !== 9'h000 || seen !== 1'b0 || dut.pending_a !== 9'h008) begin
      errors++;
      $display("FAIL mask_hold: req_a=%h valid_seen=%b pend=%h required 000/0/008", req_a, seen, dut.pending_a);
    end
    en = 9'h008;
    wait_valid(8, n);
    checks++;
    if ({irq_bus, irq_chan} !== {2'd0, 4'd3}) begin
      errors++; $display("FAIL mask_irq: bus=%0d chan=%0d required 0/3", irq_bus, irq_chan);
    end
    ack();
    en = 9'h1FF;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int n;
    evt_a = 9'h004;
    tick();
    evt_a = 9'h000;
    wait_valid(10, n);
    irq_ready = 1'b1;
    evt_a = 9'h004;
    tick();
    irq_ready = 1'b0;
    evt_a = 9'h000;
    checks++;
    if (dut.pending_a[2] !== 1'b1 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_set_wins: pend2=%b valid=%b required 1/0", dut.pending_a[2], irq_valid);
    end
    wait_valid(10, n);
    checks++;
    if (n !== 4 || {irq_bus, irq_chan} !== {2'd0, 4'd2}) begin
      errors++;
      $display("FAIL b2b_second: gap=%0d bus=%0d chan=%0d required 4/0/2", n, irq_bus, irq_chan);
    end
    ack();
    tick(); tick();
  endtask

  task automatic test_err();
    int n;
    logic seen_valid;
    force_bad = 1'b1;
    evt_a = 9'h001;
    tick();
    evt_a = 9'h000;
    n = 0;
    seen_valid = 1'b0;
    while (!err_code && n < 10) begin
      tick();
      n++;
      if (irq_valid) seen_valid = 1'b1;
    end
    checks++;
    if (err_code !== 1'b1 || seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b valid_seen=%b required 1/0", err_code, seen_valid);
    end
    tick();
    force_bad = 1'b0;
    checks++;
    if (err_code !== 1'b0 || irq_valid !== 1'b0 || dut.pending_a !== 9'h001) begin
      errors++;
      $display("FAIL err_after: err=%b valid=%b pend=%h required 0/0/001", err_code, irq_valid, dut.pending_a);
    end
    wait_valid(10, n);
    checks++;
    if ({irq_bus, irq_chan} !== {2'd0, 4'd0}) begin
      errors++; $display("FAIL err_rearb: bus=%0d chan=%0d required 0/0", irq_bus, irq_chan);
    end
    ack();
    tick(); tick();
  endtask

  task automatic test_en_drop();
    int n;
    evt_b = 9'h010;
    tick();
    evt_b = 9'h000;
    wait_valid(10, n);
    en = 9'h000;
    ack();
    checks++;
    if (dut.pending_b !== 9'h000 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL endrop: pend_b=%h valid=%b required 000/0", dut.pending_b, irq_valid);
    end
    en = 9'h1FF;
    tick(); tick();
  endtask

  task automatic test_reset_in_ack();
    int n;
    evt_c = 9'h020;
    tick();
    evt_c = 9'h000;
    wait_valid(10, n);
    evt_a = 9'h080;
    tick();
    evt_a = 9'h000;
    rst_n = 1'b0;
    tick();
    checks++;
    if (irq_valid !== 1'b0 || {req_a, req_b, req_c, req_e} !== 36'h0 ||
        {dut.pending_a, dut.pending_b, dut.pending_c} !== 27'h0) begin
      errors++;
      $display("FAIL rst_ack: valid=%b req=%h pend=%h required 0/0/0", irq_valid,
               {req_a, req_b, req_c, req_e}, {dut.pending_a, dut.pending_b, dut.pending_c});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (irq_valid !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: valid=%b required 0", irq_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    evt_a = '0; evt_b = '0; evt_c = '0; en = '0;
    irq_ready = 1'b0;
    force_bad = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_two_buses();
    test_enable_mask();
    test_back_to_back();
    test_err();
    test_en_drop();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
